alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage datapath block for the single-cycle MIPS-style core.
- Merges three functions:
  - ALU control decode: ALUOp plus funct field to a 3-bit ALU operation.
  - 32-bit ALU producing result and zero flag.
  - The two PC adders: PC+4, and PC+4 plus the pre-shifted branch offset.
- All outputs are registered, so the block presents a one-cycle-latency execute result to memory/writeback and PC-select logic.

Parameters:
- WIDTH, 32, datapath width of operands, result and PC.
- PC_INC, 4, constant added to pc by the first adder.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when low, registered outputs hold.
- aluop1  input  1  ALUOp bit 1 from main control.
- aluop0  input  1  ALUOp bit 0 from main control.
- andisignal  input  1  forces AND operation (andi instruction).
- funct  input  4  instruction bits [3:0].
- dataa  input  WIDTH  ALU operand A (register read data 1).
- datab  input  WIDTH  ALU operand B (register data or sign-extended immediate, muxed upstream).
- pc  input  WIDTH  current program counter.
- sextad  input  WIDTH  sign-extended offset already shifted left by 2.
- sum  output  WIDTH  registered ALU result.
- zout  output  1  registered zero flag.
- gout  output  3  registered ALU operation code.
- adder1out  output  WIDTH  registered pc + PC_INC.
- adder2out  output  WIDTH  registered (pc + PC_INC) + sextad.

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-high. While reset=1, all outputs are 0, including zout=0, and this takes effect immediately without a clock edge. The first capture happens on the first rising clk edge after reset deasserts.
- ALU control decode is combinational, highest priority first:
  - andisignal=1 -> 000 (AND).
  - aluop1=0, aluop0=0 -> 010 (ADD, load/store).
  - aluop1=0, aluop0=1 -> 110 (SUB, beq).
  - aluop1=1 (aluop0 don't-care) -> decode funct:
    - 0000 -> 010 ADD
    - 0010 -> 110 SUB
    - 0100 -> 000 AND
    - 0101 -> 001 OR
    - 1010 -> 111 SLT
    - any other funct -> 010 ADD
- ALU, combinational on dataa and datab under the decoded code:
  - 000 -> A & B.
  - 001 -> A | B.
  - 010 -> A + B, modulo 2^WIDTH, carry and overflow discarded.
  - 110 -> A - B, modulo 2^WIDTH.
  - 111 -> 1 if signed(A) < signed(B), else 0, zero-extended to WIDTH.
  - Unused codes 011, 100, 101 -> result 0.
- Zero flag: 1 exactly when the ALU result equals 0.
- Adders: adder1out = pc + PC_INC; adder2out = (pc + PC_INC) + sextad. Both wrap modulo 2^WIDTH with no carry out.
- Registering: on a rising clk edge with reset=0 and en=1, sum, zout, gout, adder1out and adder2out all capture their combinational values. With en=0 they hold. Latency from inputs to outputs is exactly 1 cycle.
- Reset asserted mid-operation clears the outputs immediately; any pending capture is discarded.

Test Plan:
- Reset: assert reset with en=1 and nonzero inputs -> all outputs 0 (zout=0) immediately and through clock edges; deassert -> next edge captures the inputs.
- lw/sw add: aluop=00, dataa=0x00000010, datab=0x00000004 -> one cycle later sum=0x00000014, gout=010, zout=0.
- beq sub: aluop=01, dataa=datab=0x12345678, pc=0x00000008, sextad=0xFFFFFFF8 -> sum=0, zout=1, gout=110, adder1out=0x0000000C, adder2out=0x00000004.
- R-type sweep with aluop=10, dataa=0xF0F0000F, datab=0x0FF00005:
  - funct 0100 -> sum=0x00F00005.
  - funct 0101 -> sum=0xFFF0000F.
  - funct 0010 -> sum=0xE100000A.
  - funct 1010 -> sum=0x00000001 (signed negative < positive).
  - funct 1111 -> falls back to ADD, sum=0x00E00014.
- andi override: andisignal=1 with aluop=01, dataa=0x0000FFFF, datab=0x000000F0 -> gout=000, sum=0x000000F0.
- Wrap and hold: ADD of dataa=0xFFFFFFFF, datab=0x00000001 -> sum=0, zout=1. Then drop en and change inputs -> outputs unchanged for 3 cycles.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage block for the single-cycle MIPS-style core: ALU control decode, 32-bit ALU and
// the two PC adders. All results are registered to give a one-cycle execute latency.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             aluop1_i,
  input  logic             aluop0_i,
  input  logic             andisignal_i,
  input  logic [3:0]       funct_i,
  input  logic [WIDTH-1:0] dataa_i,
  input  logic [WIDTH-1:0] datab_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] sextad_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             zout_o,
  output logic [2:0]       gout_o,
  output logic [WIDTH-1:0] adder1out_o,
  output logic [WIDTH-1:0] adder2out_o
);

  typedef enum logic [2:0] {
    OpAnd = 3'b000,
    OpOr  = 3'b001,
    OpAdd = 3'b010,
    OpSub = 3'b110,
    OpSlt = 3'b111
  } alu_op_e;

  localparam logic [WIDTH-1:0] PcInc = WIDTH'(PC_INC);

  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [WIDTH-1:0] pc_plus_inc;
  logic [WIDTH-1:0] branch_tgt;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             zout_d, zout_q;
  logic [2:0]       gout_d, gout_q;
  logic [WIDTH-1:0] adder1_d, adder1_q;
  logic [WIDTH-1:0] adder2_d, adder2_q;

  // ALU control: andi override beats ALUOp, ALUOp=1x defers to funct.
  always_comb begin
    alu_op = OpAdd;
    if (andisignal_i) begin
      alu_op = OpAnd;
    end else if (!aluop1_i) begin
      alu_op = aluop0_i ? OpSub : OpAdd;
    end else begin
      case (funct_i)
        4'b0000: alu_op = OpAdd;
        4'b0010: alu_op = OpSub;
        4'b0100: alu_op = OpAnd;
        4'b0101: alu_op = OpOr;
        4'b1010: alu_op = OpSlt;
        default: alu_op = OpAdd;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAnd:   alu_res = dataa_i & datab_i;
      OpOr:    alu_res = dataa_i | datab_i;
      OpAdd:   alu_res = dataa_i + datab_i;
      OpSub:   alu_res = dataa_i - datab_i;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataa_i) < $signed(datab_i))};
      default: alu_res = '0;
    endcase
  end

  assign alu_zero    = (alu_res == '0);
  assign pc_plus_inc = pc_i + PcInc;
  assign branch_tgt  = pc_plus_inc + sextad_i;

  always_comb begin
    sum_d    = sum_q;
    zout_d   = zout_q;
    gout_d   = gout_q;
    adder1_d = adder1_q;
    adder2_d = adder2_q;
    if (en_i) begin
      sum_d    = alu_res;
      zout_d   = alu_zero;
      gout_d   = alu_op;
      adder1_d = pc_plus_inc;
      adder2_d = branch_tgt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sum_q    <= '0;
      zout_q   <= 1'b0;
      gout_q   <= '0;
      adder1_q <= '0;
      adder2_q <= '0;
    end else begin
      sum_q    <= sum_d;
      zout_q   <= zout_d;
      gout_q   <= gout_d;
      adder1_q <= adder1_d;
      adder2_q <= adder2_d;
    end
  end

  assign sum_o       = sum_q;
  assign zout_o      = zout_q;
  assign gout_o      = gout_q;
  assign adder1out_o = adder1_q;
  assign adder2out_o = adder2_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan cases plus randomized traffic
// compared against a behavioural reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         a1;
  logic         a0;
  logic         andi;
  logic [3:0]   funct;
  logic [W-1:0] da;
  logic [W-1:0] db;
  logic [W-1:0] pc;
  logic [W-1:0] sx;
  logic [W-1:0] sum;
  logic         zout;
  logic [2:0]   gout;
  logic [W-1:0] add1;
  logic [W-1:0] add2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         z;
    logic [2:0]   g;
    logic [W-1:0] a1;
    logic [W-1:0] a2;
  } exp_t;

  exp_t exp_q;

  alu_exec_unit #(
    .WIDTH (W),
    .PC_INC(4)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .en_i        (en),
    .aluop1_i    (a1),
    .aluop0_i    (a0),
    .andisignal_i(andi),
    .funct_i     (funct),
    .dataa_i     (da),
    .datab_i     (db),
    .pc_i        (pc),
    .sextad_i    (sx),
    .sum_o       (sum),
    .zout_o      (zout),
    .gout_o      (gout),
    .adder1out_o (add1),
    .adder2out_o (add2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference model straight from the decode table and arithmetic rules.
  function automatic exp_t model();
    exp_t e;
    longint unsigned wrap = 64'h1_0000_0000;
    int op;
    if (andi) op = 0;
    else if (!a1 && !a0) op = 2;
    else if (!a1) op = 6;
    else if (funct == 4'd0) op = 2;
    else if (funct == 4'd2) op = 6;
    else if (funct == 4'd4) op = 0;
    else if (funct == 4'd5) op = 1;
    else if (funct == 4'd10) op = 7;
    else op = 2;
    e.g = 3'(op);
    if (op == 0) e.sum = da & db;
    else if (op == 1) e.sum = da | db;
    else if (op == 2) e.sum = W'((longint'(da) + longint'(db)) % wrap);
    else if (op == 6) e.sum = W'((longint'(da) + wrap - longint'(db)) % wrap);
    else e.sum = (int'(da) < int'(db)) ? 1 : 0;
    e.z  = (e.sum == 0);
    e.a1 = W'((longint'(pc) + 4) % wrap);
    e.a2 = W'((longint'(pc) + 4 + longint'(sx)) % wrap);
    return e;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_sum"}, sum, exp_q.sum);
    check({tag, "_zout"}, W'(zout), W'(exp_q.z));
    check({tag, "_gout"}, W'(gout), W'(exp_q.g));
    check({tag, "_add1"}, add1, exp_q.a1);
    check({tag, "_add2"}, add2, exp_q.a2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"}, sum, '0);
    check({tag, "_zout"}, W'(zout), '0);
    check({tag, "_gout"}, W'(gout), '0);
    check({tag, "_add1"}, add1, '0);
    check({tag, "_add2"}, add2, '0);
  endtask

  // Advance one edge; the model captures the inputs that were stable before it.
  task automatic tick(input string tag);
    exp_t nxt = model();
    @(posedge clk);
    #1;
    if (en) exp_q = nxt;
    check_all(tag);
  endtask

  task automatic drive(input logic x1, input logic x0, input logic xa, input logic [3:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    a1 = x1; a0 = x0; andi = xa; funct = f; da = a; db = b;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'b0101, 32'hDEAD_BEEF, 32'h1234_5678);
    pc = 32'h0000_1000;
    sx = 32'h0000_0040;
    #1 rst = 1'b1;
    #1 check_zero("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_zero("rst_hold");
    end
    exp_q = '0;
    @(negedge clk) rst = 1'b0;
    tick("rst_release");

    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0004);
    tick("lw_add");
    check("lw_add_const", sum, 32'h0000_0014);

    drive(1'b0, 1'b1, 1'b0, 4'b0000, 32'h1234_5678, 32'h1234_5678);
    pc = 32'h0000_0008;
    sx = 32'hFFFF_FFF8;
    tick("beq_sub");
    check("beq_zout_const", W'(zout), 1);
    check("beq_add1_const", add1, 32'h0000_000C);
    check("beq_add2_const", add2, 32'h0000_0004);

    drive(1'b1, 1'b0, 1'b0, 4'b0100, 32'hF0F0_000F, 32'h0FF0_0005);
    tick("r_and");
    check("r_and_const", sum, 32'h00F0_0005);
    funct = 4'b0101; tick("r_or");
    check("r_or_const", sum, 32'hFFF0_000F);
    funct = 4'b0010; tick("r_sub");
    check("r_sub_const", sum, 32'hE100_000A);
    funct = 4'b1010; tick("r_slt");
    check("r_slt_const", sum, 32'h0000_0001);
    funct = 4'b1111; tick("r_dflt");
    check("r_dflt_const", sum, 32'h00E0_0014);

    drive(1'b0, 1'b1, 1'b1, 4'b0000, 32'h0000_FFFF, 32'h0000_00F0);
    tick("andi");
    check("andi_gout_const", W'(gout), 0);
    check("andi_sum_const", sum, 32'h0000_00F0);

    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    tick("wrap");
    check("wrap_zout_const", W'(zout), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0101, $urandom, $urandom);
      pc = $urandom;
      tick("hold");
    end
    en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [3:0] legal [6] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd10, 4'd15};
      a1    = 1'($urandom);
      a0    = 1'($urandom);
      andi  = ($urandom_range(0, 7) == 0);
      funct = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 5)];
      da    = $urandom;
      db    = ($urandom_range(0, 5) == 0) ? da : $urandom;
      pc    = $urandom;
      sx    = $urandom;
      en    = ($urandom_range(0, 4) != 0);
      tick("rand");
    end

    // Mid-operation reset must clear without waiting for an edge.
    en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0100, 32'h0000_0200);
    tick("pre_rst");
    #3 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(posedge clk);
    #1 check_zero("mid_rst_edge");
    exp_q = '0;
    @(negedge clk) rst = 1'b0;
    tick("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
